// File: rtl/usb_buf_arbiter.sv
// usb_buf_arbiter: shares one single-port packet SRAM between the SIE (fixed priority)
// and the CPU port, with a starvation counter and an SIE packet lock.
module usb_buf_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sie_req,
  input  logic          sie_we,
  input  logic [AW-1:0] sie_addr,
  input  logic [DW-1:0] sie_wdata,
  input  logic          sie_lock,
  output logic          sie_gnt,
  output logic          sie_rvalid,
  output logic [DW-1:0] sie_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          rd_pend_q, rd_pend_d, rd_src_q, rd_src_d;
  logic [DW-1:0] sie_rdata_q, cpu_rdata_q;
  logic          cpu_win;
  // Grants are gated by rst_n so every output is quiet while reset is held.
  always_comb begin
    cpu_win    = rst_n & cpu_req & ~sie_lock & (~sie_req | (wait_cnt_q == MAX_W));
    cpu_gnt    = cpu_win;
    sie_gnt    = rst_n & sie_req & ~cpu_win;
    mem_en     = sie_gnt | cpu_gnt;
    mem_we     = cpu_gnt ? cpu_we : (sie_gnt & sie_we);
    mem_addr   = cpu_gnt ? cpu_addr : (sie_gnt ? sie_addr : '0);
    mem_wdata  = cpu_gnt ? cpu_wdata : (sie_gnt ? sie_wdata : '0);
    sie_rvalid = rd_pend_q & ~rd_src_q;
    cpu_rvalid = rd_pend_q & rd_src_q;
    sie_rdata  = sie_rvalid ? mem_rdata : sie_rdata_q;
    cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    rd_pend_d  = mem_en & ~mem_we;
    rd_src_d   = cpu_gnt;
    wait_cnt_d = (cpu_req & ~cpu_gnt) ? ((wait_cnt_q == MAX_W) ? MAX_W : wait_cnt_q + 4'd1) : 4'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      rd_src_q    <= 1'b0;
      sie_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_src_q    <= rd_src_d;
      sie_rdata_q <= sie_rdata;
      cpu_rdata_q <= cpu_rdata;
    end
  end
endmodule

// File: tb/tb_usb_buf_arbiter.sv
// tb_usb_buf_arbiter: directed vector table, corner sequences and randomized traffic
// checked against a transaction-level arbitration/memory model.
module tb_usb_buf_arbiter;
  localparam int MAXW = 4;
  logic clk = 0, rst_n = 0;
  logic sie_req = 0, sie_we = 0, sie_lock = 0, cpu_req = 0, cpu_we = 0;
  logic [7:0] sie_addr = 0, sie_wdata = 0, cpu_addr = 0, cpu_wdata = 0;
  logic sie_gnt, sie_rvalid, cpu_gnt, cpu_rvalid, mem_en, mem_we;
  logic [7:0] sie_rdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [7:0] sram [256];
  int n_cmp = 0, n_bad = 0;

  usb_buf_arbiter #(.AW(8), .DW(8), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .sie_req(sie_req), .sie_we(sie_we), .sie_addr(sie_addr), .sie_wdata(sie_wdata),
    .sie_lock(sie_lock), .sie_gnt(sie_gnt), .sie_rvalid(sie_rvalid), .sie_rdata(sie_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  // SRAM macro: registered read, one cycle latency
  always @(posedge clk) begin
    if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
  end

  // Reference model state: stall age, one outstanding read, shadow memory, last returned data
  int stall;
  bit pv, ps;
  logic [7:0] pd, last_s, last_c;
  logic [7:0] ref_mem [256];
  bit e_sg, e_cg;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    stall = 0; pv = 0; ps = 0; pd = 0; last_s = 0; last_c = 0;
  endfunction

  task automatic drive(bit sr, bit sw, logic [7:0] sa, logic [7:0] sd, bit lk,
                       bit cr, bit cw, logic [7:0] ca, logic [7:0] cd);
    sie_req = sr; sie_we = sw; sie_addr = sa; sie_wdata = sd; sie_lock = lk;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
  endtask

  // Check the current cycle at the falling edge against the model
  task automatic check_cycle();
    bit srv, crv;
    @(negedge clk);
    e_cg = cpu_req && !sie_lock && (!sie_req || stall == MAXW);
    e_sg = sie_req && !e_cg;
    srv = pv && !ps;
    crv = pv && ps;
    chk("sie_gnt", sie_gnt, e_sg);
    chk("cpu_gnt", cpu_gnt, e_cg);
    chk("mem_en", mem_en, e_sg || e_cg);
    chk("mem_we", mem_we, e_cg ? cpu_we : (e_sg && sie_we));
    chk("mem_addr", mem_addr, e_cg ? cpu_addr : (e_sg ? sie_addr : 8'h0));
    chk("mem_wdata", mem_wdata, e_cg ? cpu_wdata : (e_sg ? sie_wdata : 8'h0));
    chk("sie_rvalid", sie_rvalid, srv);
    chk("cpu_rvalid", cpu_rvalid, crv);
    chk("sie_rdata", sie_rdata, srv ? pd : last_s);
    chk("cpu_rdata", cpu_rdata, crv ? pd : last_c);
  endtask

  // Advance the model by one accepted cycle and move to just after the next rising edge
  task automatic end_cycle();
    bit g, w;
    logic [7:0] a, d;
    if (pv && !ps) last_s = pd;
    if (pv && ps) last_c = pd;
    g = e_sg || e_cg;
    w = e_cg ? cpu_we : sie_we;
    a = e_cg ? cpu_addr : sie_addr;
    d = e_cg ? cpu_wdata : sie_wdata;
    pv = g && !w;
    ps = e_cg;
    if (g && !w) pd = ref_mem[a];
    if (g && w) ref_mem[a] = d;
    stall = (cpu_req && !e_cg) ? ((stall + 1 > MAXW) ? MAXW : stall + 1) : 0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit sr, sw; logic [7:0] sa, sd; bit lk;
    bit cr, cw; logic [7:0] ca, cd;
    bit xsg, xcg, xsrv, xcrv; logic [7:0] xsrd, xcrd;
  } vec_t;
  vec_t vt [9];

  int cg_cnt;
  bit creq_r, cwe_r;
  logic [7:0] cad_r, cwd_r;
  int lock_left;

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i] = 8'(i) ^ 8'hB5;
      ref_mem[i] = 8'(i) ^ 8'hB5;
    end
    model_reset();
    //           sr sw sa     sd     lk cr cw ca     cd     sg cg srv crv srd    crd
    vt[0] = '{1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00};
    vt[1] = '{0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'hA5, 8'h00};
    vt[2] = '{0, 0, 8'h00, 8'h00, 0, 1, 1, 8'h7F, 8'h3C, 0, 1, 0, 0, 8'hA5, 8'h00};
    vt[3] = '{1, 0, 8'h7F, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'hA5, 8'h00};
    vt[4] = '{1, 0, 8'h01, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h3C, 8'h00};
    vt[5] = '{0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h02, 8'h00, 0, 1, 1, 0, 8'hB4, 8'h00};
    vt[6] = '{1, 0, 8'h01, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'hB4, 8'hB7};
    vt[7] = '{0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h02, 8'h00, 0, 1, 1, 0, 8'hB4, 8'hB7};
    vt[8] = '{0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'hB4, 8'hB7};

    // Reset state: outputs quiet even with requests present
    drive(1, 1, 8'h33, 8'h44, 0, 1, 1, 8'h55, 8'h66);
    #12;
    chk("rst_sie_gnt", sie_gnt, 0);
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Directed table: SIE read, CPU write then SIE readback, alternating reads
    foreach (vt[i]) begin
      drive(vt[i].sr, vt[i].sw, vt[i].sa, vt[i].sd, vt[i].lk, vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd);
      check_cycle();
      chk($sformatf("vec%0d_sgnt", i), sie_gnt, vt[i].xsg);
      chk($sformatf("vec%0d_cgnt", i), cpu_gnt, vt[i].xcg);
      chk($sformatf("vec%0d_srv", i), sie_rvalid, vt[i].xsrv);
      chk($sformatf("vec%0d_crv", i), cpu_rvalid, vt[i].xcrv);
      chk($sformatf("vec%0d_srd", i), sie_rdata, vt[i].xsrd);
      chk($sformatf("vec%0d_crd", i), cpu_rdata, vt[i].xcrd);
      end_cycle();
    end

    // Both requesting continuously: CPU wins every fifth slot
    cg_cnt = 0;
    drive(1, 0, 8'h20, 0, 0, 1, 0, 8'h21, 0);
    for (int i = 0; i < 15; i++) begin
      check_cycle();
      chk($sformatf("fair%0d_cgnt", i), cpu_gnt, (i % 5) == 4);
      cg_cnt += int'(cpu_gnt);
      end_cycle();
    end
    chk("fair_total", cg_cnt, 3);

    // Lock held 20 cycles: CPU starved, then wins on the first unlocked cycle
    cg_cnt = 0;
    drive(1, 0, 8'h20, 0, 1, 1, 1, 8'h22, 8'h99);
    for (int i = 0; i < 20; i++) begin
      check_cycle();
      cg_cnt += int'(cpu_gnt);
      end_cycle();
    end
    chk("lock_cpu_gnts", cg_cnt, 0);
    sie_lock = 0;
    check_cycle();
    chk("unlock_cpu_gnt", cpu_gnt, 1);
    chk("unlock_sie_gnt", sie_gnt, 0);
    end_cycle();
    check_cycle();
    chk("after_unlock_sie_gnt", sie_gnt, 1);
    end_cycle();

    // CPU drops request before grant: counter clears, SIE keeps priority
    drive(1, 0, 8'h20, 0, 0, 1, 0, 8'h23, 0);
    for (int i = 0; i < 3; i++) begin check_cycle(); end_cycle(); end
    cpu_req = 0;
    check_cycle(); end_cycle();
    cpu_req = 1;
    for (int i = 0; i < 4; i++) begin
      check_cycle();
      chk($sformatf("drop%0d_cgnt", i), cpu_gnt, 0);
      end_cycle();
    end
    check_cycle();
    chk("drop_cgnt_at_max", cpu_gnt, 1);
    end_cycle();

    // Reset in the cycle after a granted read: return discarded, grant right after release
    drive(1, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    check_cycle();
    chk("prerst_sgnt", sie_gnt, 1);
    end_cycle();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    chk("inrst_srv", sie_rvalid, 0);
    chk("inrst_sgnt", sie_gnt, 0);
    chk("inrst_mem_en", mem_en, 0);
    chk("inrst_srd", sie_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 1, 0, 8'h10, 0);
    check_cycle();
    chk("postrst_cgnt", cpu_gnt, 1);
    chk("postrst_srv", sie_rvalid, 0);
    end_cycle();
    check_cycle();
    chk("postrst_crd", cpu_rdata, 8'hA5);
    end_cycle();

    // Random traffic; CPU holds its request until granted or abandons it
    creq_r = 0; cwe_r = 0; cad_r = 0; cwd_r = 0; lock_left = 0;
    for (int i = 0; i < 400; i++) begin
      if (!creq_r || $urandom_range(0, 15) == 0) begin
        creq_r = $urandom_range(0, 2) != 0;
        cwe_r = $urandom_range(0, 1) == 1;
        cad_r = 8'($urandom_range(0, 7));
        cwd_r = 8'($urandom);
      end
      if (lock_left > 0) lock_left--;
      else if ($urandom_range(0, 19) == 0) lock_left = $urandom_range(1, 12);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 7)),
            8'($urandom), lock_left > 0, creq_r, cwe_r, cad_r, cwd_r);
      check_cycle();
      if (cpu_gnt) creq_r = 0;
      end_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
